// File: rtl/alu_issue_scheduler.sv
// Issue scheduler for a pipelined ALU whose unit paths share one result bus.
// Optional statistics counters are enabled with the ALU_SCHED_STATS_EN macro.
module alu_issue_scheduler #(
    parameter int TAG_W     = 4,
    parameter int LAT_ARITH = 8,
    parameter int LAT_LOGIC = 31,
    parameter int LAT_SHIFT = 27,
    parameter int MAX_OUT   = 8,
    parameter int MAX_LAT   = 31
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [4:0]                     in_opcode,
    input  logic [31:0]                    in_a,
    input  logic [31:0]                    in_b,
    input  logic [TAG_W-1:0]               in_tag,
    output logic [31:0]                    alu_a,
    output logic [31:0]                    alu_b,
    output logic [4:0]                     alu_opcode,
    output logic                           wb_valid,
    output logic [TAG_W-1:0]               wb_tag,
    output logic                           illegal,
    output logic [TAG_W-1:0]               illegal_tag,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [15:0]                    collide_cnt
`endif
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int IDX_W = $clog2(MAX_LAT + 1);

    // resv_q holds slots 0..MAX_LAT-1; slot MAX_LAT is the constant-zero top.
    logic [MAX_LAT-1:0] resv_q;
    logic [MAX_LAT:0]   resv;
    logic [TAG_W-1:0]   slot_tag_q [MAX_LAT];

    logic [1:0]       cls;
    logic             is_illegal;
    logic [IDX_W-1:0] lat;
    logic [IDX_W-1:0] lat_m1;
    logic             slot_busy;
    logic             credit_ok;
    logic             accept;
    logic             issue;

    assign resv = {1'b0, resv_q};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cls        = in_opcode[4:3];
        is_illegal = (cls == 2'b11);
        lat        = IDX_W'(LAT_ARITH);
        case (cls)
            2'b01:   lat = IDX_W'(LAT_LOGIC);
            2'b10:   lat = IDX_W'(LAT_SHIFT);
            default: lat = IDX_W'(LAT_ARITH);
        endcase
    end

    // A set resv[lat] would shift into the slot this op wants next cycle.
    assign lat_m1    = lat - IDX_W'(1);
    assign slot_busy = resv[lat];
    assign credit_ok = (outstanding < OUT_W'(MAX_OUT)) || wb_valid;
    assign in_ready  = is_illegal || (!slot_busy && credit_ok);
    assign accept    = in_valid && in_ready;
    assign issue     = accept && !is_illegal;

    assign wb_valid = resv[0];
    assign wb_tag   = slot_tag_q[0];
    assign busy     = (outstanding != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the tag array is reset too, so a stale tag never reappears on wb_tag.
            resv_q      <= '0;
            for (int k = 0; k < MAX_LAT; k++) slot_tag_q[k] <= '0;
            outstanding <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            illegal     <= 1'b0;
            illegal_tag <= '0;
        end else begin
            // NOTE: non-blocking updates; the later accept write overrides the shift.
            resv_q <= resv[MAX_LAT:1];
            for (int k = 0; k < MAX_LAT - 1; k++) slot_tag_q[k] <= slot_tag_q[k+1];
            slot_tag_q[MAX_LAT-1] <= '0;
            alu_opcode <= 5'b00000;
            illegal    <= 1'b0;

            if (issue) begin
                resv_q[lat_m1]     <= 1'b1;
                slot_tag_q[lat_m1] <= in_tag;
                alu_opcode         <= in_opcode;
                alu_a              <= in_a;
                alu_b              <= in_b;
            end

            if (accept && is_illegal) begin
                illegal     <= 1'b1;
                illegal_tag <= in_tag;
            end

            case ({issue, wb_valid})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            collide_cnt <= '0;
        end else begin
            if (in_valid && !in_ready)
                stall_cnt <= stall_cnt + 32'd1;
            if (in_valid && !is_illegal && slot_busy)
                collide_cnt <= collide_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Randomized bench for alu_issue_scheduler checked against a completion-time model.
// The model keeps a list of in-flight ops with the edge at which each result appears.
module tb_alu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic        illegal;
    logic [3:0]  illegal_tag;
    logic [3:0]  outstanding;
    logic        busy;
`ifdef ALU_SCHED_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] collide_cnt;
`endif

    alu_issue_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .illegal     (illegal),
        .illegal_tag (illegal_tag),
        .outstanding (outstanding),
        .busy        (busy)
`ifdef ALU_SCHED_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .collide_cnt (collide_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         done;
        logic [3:0] tag;
    } op_t;

    op_t         q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          checking = 0;
    logic [4:0]  exp_opcode;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_illegal;
    logic [3:0]  exp_illegal_tag;
    longint      exp_stall;
    longint      exp_collide;

    function automatic int lat_of(input logic [1:0] c);
        case (c)
            2'b00:   return 8;
            2'b01:   return 31;
            2'b10:   return 27;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // One cycle: drive, compare against the model, take the edge, advance the model.
    task automatic step(input logic r, input logic v, input logic [4:0] op,
                        input logic [3:0] tg, output logic acc);
        int         outst;
        int         l;
        logic       wbv;
        logic [3:0] wbt;
        logic       coll;
        logic       rdy;
        logic [31:0] a_now;
        logic [31:0] b_now;
        rst_n     = r;
        in_valid  = v;
        in_opcode = op;
        a_now     = $urandom;
        b_now     = $urandom;
        in_a      = a_now;
        in_b      = b_now;
        in_tag    = tg;
        #2;
        outst = q.size();
        wbv   = 1'b0;
        wbt   = 4'd0;
        foreach (q[i]) if (q[i].done == cyc) begin wbv = 1'b1; wbt = q[i].tag; end
        l    = lat_of(op[4:3]);
        coll = 1'b0;
        foreach (q[i]) if (q[i].done == cyc + l) coll = 1'b1;
        if (op[4:3] == 2'b11) begin
            rdy  = 1'b1;
            coll = 1'b0;
        end else begin
            rdy = !coll && (outst < 8 || wbv);
        end

        if (checking) begin
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("wb_valid", 32'(wb_valid), 32'(wbv));
            if (wbv) check("wb_tag", 32'(wb_tag), 32'(wbt));
            check("outstanding", 32'(outstanding), 32'(outst));
            check("busy", 32'(busy), 32'(outst != 0));
            check("alu_opcode", 32'(alu_opcode), 32'(exp_opcode));
            check("alu_a", alu_a, exp_a);
            check("alu_b", alu_b, exp_b);
            check("illegal", 32'(illegal), 32'(exp_illegal));
            if (exp_illegal) check("illegal_tag", 32'(illegal_tag), 32'(exp_illegal_tag));
`ifdef ALU_SCHED_STATS_EN
            check("stall_cnt", stall_cnt, 32'(exp_stall));
            check("collide_cnt", 32'(collide_cnt), 32'(exp_collide[15:0]));
`endif
        end

        @(posedge clk);
        acc = r && v && rdy;
        if (!r) begin
            q.delete();
            exp_opcode      = 5'd0;
            exp_a           = 32'd0;
            exp_b           = 32'd0;
            exp_illegal     = 1'b0;
            exp_illegal_tag = 4'd0;
            exp_stall       = 0;
            exp_collide     = 0;
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].done == cyc) q.delete(i);
            exp_opcode  = 5'd0;
            exp_illegal = 1'b0;
            if (v && !rdy) exp_stall = (exp_stall + 1) % 64'h1_0000_0000;
            if (v && coll) exp_collide = (exp_collide + 1) % 65536;
            if (acc) begin
                if (op[4:3] == 2'b11) begin
                    exp_illegal     = 1'b1;
                    exp_illegal_tag = tg;
                end else begin
                    q.push_back('{done: cyc + l, tag: tg});
                    exp_opcode = op;
                    exp_a      = a_now;
                    exp_b      = b_now;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'($urandom), 4'($urandom), acc);
    endtask

    // Hold an operation until the model says it is taken, with a cycle bound.
    task automatic offer(input logic [4:0] op, input logic [3:0] tg);
        logic acc;
        int   n;
        n = 0;
        do begin
            step(1'b1, 1'b1, op, tg, acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL offer_timeout: op 0x%0h not accepted within %0d cycles", op, n);
        end
    endtask

    function automatic logic [4:0] rand_op();
        int w;
        logic [1:0] c;
        w = $urandom_range(0, 99);
        if (w < 50)      c = 2'b00;
        else if (w < 70) c = 2'b01;
        else if (w < 90) c = 2'b10;
        else             c = 2'b11;
        return {c, 3'($urandom)};
    endfunction

    initial begin
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_opcode = 5'b00001;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 5'b00001, 4'd1, acc);
        checking = 1;
        step(1'b0, 1'b1, 5'b01001, 4'd2, acc);
        step(1'b0, 1'b1, 5'b10001, 4'd3, acc);

        offer(5'b00001, 4'd3);
        idle(10);

        offer(5'b01000, 4'd1);
        idle(3);
        offer(5'b10000, 4'd2);
        idle(35);

        for (int i = 0; i < 20; i++) offer(5'b00010, 4'(i));
        idle(12);

        offer(5'b11010, 4'd7);
        idle(3);

        offer(5'b01011, 4'd9);
        offer(5'b10011, 4'd10);
        offer(5'b00011, 4'd11);
        idle(2);
        step(1'b0, 1'b0, 5'b00000, 4'd0, acc);
        offer(5'b00001, 4'd5);
        idle(40);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic v;
            int   dens;
            dens = (i / 500) % 3 == 0 ? 90 : ((i / 500) % 3 == 1 ? 40 : 70);
            r = ($urandom_range(0, 399) != 0);
            v = ($urandom_range(0, 99) < dens);
            step(r, v, rand_op(), 4'($urandom), acc);
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
Issue controller in front of the pipelined ALU. Its unit paths (arithmetic, logic, shift/rotate) have different fixed latencies but share one result bus. The block accepts operations over a valid/ready handshake and registers them into the ALU. It reserves the writeback slot each operation will occupy and stalls any operation whose result would collide with one already in flight. It returns a tagged writeback strobe aligned with the ALU result.

Parameters:
TAG_W, 4, width of the destination tag carried with each operation
LAT_ARITH, 8, edges from the accept edge until the ALU result for class 2'b00 is sampled
LAT_LOGIC, 31, same, for class 2'b01
LAT_SHIFT, 27, same, for class 2'b10
MAX_OUT, 8, maximum number of operations in flight
MAX_LAT, 31, largest of the three latencies; sizes the reservation vector

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  scheduler can accept this cycle (combinational)
in_opcode  in  5  ALU opcode; [4:3] is the unit class
in_a  in  32  operand A
in_b  in  32  operand B
in_tag  in  TAG_W  destination tag
alu_a  out  32  registered operand A to the ALU
alu_b  out  32  registered operand B to the ALU
alu_opcode  out  5  registered opcode to the ALU
wb_valid  out  1  the ALU result is valid this cycle
wb_tag  out  TAG_W  tag of the result marked by wb_valid
illegal  out  1  one-cycle pulse: a class 2'b11 operation was consumed
illegal_tag  out  TAG_W  tag of that illegal operation
outstanding  out  $clog2(MAX_OUT+1)  number of operations in flight
busy  out  1  outstanding != 0

Behaviour:
- Handshake: an operation is accepted at an edge where in_valid && in_ready.
- Latency selection: L = LAT_ARITH, LAT_LOGIC or LAT_SHIFT, chosen by in_opcode[4:3]. in_ready depends on in_opcode but never on in_valid.
- Reservation vector resv[0..MAX_LAT] with tag array slot_tag[0..MAX_LAT]. resv[MAX_LAT] is constant 0.
  - Every edge: resv[k] <= resv[k+1] and slot_tag[k] <= slot_tag[k+1].
  - On accept: resv[L-1] <= 1 and slot_tag[L-1] <= in_tag; these writes override the shift.
- Writeback: wb_valid = resv[0] and wb_tag = slot_tag[0]. An operation accepted at edge e is sampled with wb_valid=1 and its tag at edge e+L.
- in_ready for classes 00, 01 and 10 = !resv[L] && (outstanding < MAX_OUT || wb_valid).
  - The resv[L] term blocks writeback collisions.
  - A retiring operation frees its credit in the same cycle.
- Class 2'b11:
  - in_ready = 1; the operation is consumed without a reservation and without touching the ALU outputs.
  - illegal pulses high for the one cycle after the accept edge, with illegal_tag = in_tag.
- ALU drive:
  - On accept of classes 00, 01 and 10, alu_opcode, alu_a and alu_b register the inputs.
  - On every other edge, alu_opcode <= 5'b00000 and alu_a/alu_b hold.
- outstanding: +1 on a non-illegal accept, -1 when wb_valid is high at an edge. Both at the same edge leave it unchanged. Saturation is impossible by construction.
- Reset (including mid-operation):
  - resv, slot_tag, outstanding, alu_a, alu_b, alu_opcode, illegal and illegal_tag all go to 0.
  - In-flight results are forgotten: wb_valid=0 from the first cycle after the reset edge, even though the ALU may still emit data.

Optional Feature:
Macro ALU_SCHED_STATS_EN.
- Defined:
  - Adds output stall_cnt [31:0], counting edges with in_valid && !in_ready. Wraps at 2^32.
  - Adds output collide_cnt [15:0], counting edges where in_valid && resv[L] (slot collision). Wraps at 2^16.
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with in_valid=1 -> all outputs 0, no accept; after release, in_ready=1 for any class.
- Single arith: accept opcode 5'b00001, tag 3, at edge 0 -> alu_opcode=00001 after edge 0; wb_valid=1 and wb_tag=3 sampled at edge 8 only; outstanding 1 over edges 0..7, then 0.
- Collision: logic tag 1 accepted at edge 0; shift tag 2 offered at edge 4 -> in_ready=0 at edge 4, accepted at edge 5; wb tag 1 at edge 31, tag 2 at edge 32; collide_cnt=1 when the macro is defined.
- Credit limit: 8 arith ops at edges 0..7, a 9th offered from edge 8 -> the 9th is accepted at edge 8 via the simultaneous retire; a 10th offered at edge 8.. with wb_valid suppressed by in-flight ordering stalls correctly; outstanding never exceeds 8.
- Illegal class: opcode 5'b11010, tag 7 -> accepted immediately; illegal=1 with illegal_tag=7 for one cycle; no wb_valid ever; outstanding unchanged.
- Reset mid-flight: 3 ops in flight, rst_n=0 for 1 edge -> outstanding=0 and no wb_valid for the stale ops; a new op then completes with its exact latency.
